// File: rtl/starfield_engine.sv
// Multi-layer scrolling starfield for the VGA ball game: LFSR-seeded star table,
// vblank scroll engine, Avalon control registers and a 2-stage pixel pipeline.
module starfield_engine #(
   parameter int          STAR_COUNT = 64,
   parameter int          LAYERS     = 4,
   parameter int          H_ACTIVE   = 640,
   parameter int          V_ACTIVE   = 480,
   parameter logic [15:0] SEED       = 16'hBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [2:0]  address,
   output logic        star_on,
   output logic [7:0]  star_r,
   output logic [7:0]  star_g,
   output logic [7:0]  star_b,
   output logic        init_done
);

   localparam int         IW    = (STAR_COUNT > 1) ? $clog2(STAR_COUNT) : 1;
   localparam int         LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_UPDATE} state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [9:0] fold_x(input logic [9:0] v);
      return (v >= H_LIM) ? v - H_LIM : v;
   endfunction

   function automatic logic [9:0] fold_y(input logic [8:0] v);
      return ({1'b0, v} >= V_LIM) ? {1'b0, v} - V_LIM : {1'b0, v};
   endfunction

   // control registers
   logic              enable, dir, tw_en;
   logic [31:0]       speed;
   logic [23:0]       color;
   logic [3:0]        tw_rate;
   logic [LAYERS-1:0] layer_en;

   logic wr_en, reseed, frame_start;
   assign wr_en       = chipselect && write;
   assign reseed      = wr_en && (address == 3'd5);
   assign frame_start = (hcount == 11'd0) && (vcount == V_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable   <= 1'b1;
         dir      <= 1'b0;
         speed    <= 32'h0000_4321;
         color    <= 24'hFFF0A0;
         tw_rate  <= 4'd1;
         tw_en    <= 1'b1;
         layer_en <= '1;
      end else if (wr_en) begin
         case (address)
            3'd0: begin
               enable <= writedata[0];
               dir    <= writedata[1];
            end
            3'd1: speed <= writedata;
            3'd2: color <= writedata[23:0];
            3'd3: begin
               tw_rate <= writedata[3:0];
               tw_en   <= writedata[8];
            end
            3'd4: layer_en <= writedata[LAYERS-1:0];
            default: ;
         endcase
      end
   end

   // sequencer state
   state_t        state;
   logic [IW-1:0] idx;
   logic [15:0]   lfsr;
   logic [7:0]    tw_acc;
   logic [31:0]   speed_act;
   logic          dir_act;
   logic          last;
   assign last = (idx == IW'(STAR_COUNT - 1));

   logic [9:0] star_x [STAR_COUNT];
   logic [9:0] star_y [STAR_COUNT];

   // speeds are snapshotted at frame start so a mid-frame SPEED write waits a frame
   logic [3:0] spd_tab [LAYERS];
   for (genvar k = 0; k < LAYERS; k++) begin : g_spd
      assign spd_tab[k] = speed_act[4*k +: 4];
   end

   logic [LW-1:0] lay;
   logic [15:0]   lfsr_s1;
   logic [9:0]    cur_y, spd, down_y, tbl_x, tbl_y;
   logic          tbl_wr_x, tbl_wr_y, upd_wrap;

   always_comb begin
      lay      = LW'(int'(idx) % LAYERS);
      lfsr_s1  = lfsr_step(lfsr);
      cur_y    = star_y[idx];
      spd      = {6'd0, spd_tab[lay]};
      down_y   = cur_y + spd;
      tbl_x    = fold_x(lfsr[9:0]);
      tbl_y    = '0;
      tbl_wr_x = 1'b0;
      tbl_wr_y = 1'b0;
      upd_wrap = 1'b0;
      if (!reseed) begin
         case (state)
            S_INIT: begin
               tbl_wr_x = 1'b1;
               tbl_wr_y = 1'b1;
               tbl_y    = fold_y(lfsr_s1[8:0]);
            end
            S_UPDATE: begin
               tbl_wr_y = 1'b1;
               if (!dir_act) begin
                  if (down_y >= V_LIM) begin
                     tbl_y    = down_y - V_LIM;
                     upd_wrap = 1'b1;
                  end else begin
                     tbl_y = down_y;
                  end
               end else if (cur_y < spd) begin
                  tbl_y    = cur_y + V_LIM - spd;
                  upd_wrap = 1'b1;
               end else begin
                  tbl_y = cur_y - spd;
               end
               tbl_wr_x = upd_wrap;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tbl_wr_x) star_x[idx] <= tbl_x;
      if (tbl_wr_y) star_y[idx] <= tbl_y;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_INIT;
         idx       <= '0;
         lfsr      <= SEED;
         tw_acc    <= '0;
         init_done <= 1'b0;
         speed_act <= 32'h0000_4321;
         dir_act   <= 1'b0;
      end else if (reseed) begin
         lfsr      <= (writedata[15:0] == 16'h0000) ? SEED : writedata[15:0];
         state     <= S_INIT;
         idx       <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               lfsr <= lfsr_step(lfsr_s1);
               if (last) begin
                  init_done <= 1'b1;
                  state     <= S_RUN;
                  idx       <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_RUN: begin
               if (frame_start) begin
                  state     <= S_UPDATE;
                  idx       <= '0;
                  tw_acc    <= tw_acc + {4'd0, tw_rate};
                  speed_act <= speed;
                  dir_act   <= dir;
               end
            end
            S_UPDATE: begin
               if (upd_wrap) lfsr <= lfsr_s1;
               if (last) begin
                  state <= S_RUN;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // pixel stage 1: lowest-index hit wins
   logic [STAR_COUNT-1:0] hit;
   for (genvar i = 0; i < STAR_COUNT; i++) begin : g_hit
      assign hit[i] = (star_x[i] == hcount[10:1]) && (star_y[i] == vcount) &&
                      layer_en[i % LAYERS] && enable && init_done;
   end

   logic          any_hit;
   logic [IW-1:0] first_idx;
   always_comb begin
      any_hit   = 1'b0;
      first_idx = '0;
      for (int unsigned i = 0; i < STAR_COUNT; i++) begin
         if (hit[i] && !any_hit) begin
            any_hit   = 1'b1;
            first_idx = IW'(i);
         end
      end
   end

   // pixel stage 2: twinkle triangle wave and colour scaling
   logic          s1_hit;
   logic [IW-1:0] s1_idx;
   logic [7:0]    phase, level;
   logic [15:0]   prod_r, prod_g, prod_b;
   always_comb begin
      phase = tw_acc + 8'(32'(s1_idx) * 32'd37);
      if (!tw_en)        level = 8'hFF;
      else if (phase[7]) level = {~phase[6:0], 1'b0};
      else               level = {phase[6:0], 1'b0};
      prod_r = 16'(color[23:16]) * 16'(level);
      prod_g = 16'(color[15:8])  * 16'(level);
      prod_b = 16'(color[7:0])   * 16'(level);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_hit  <= 1'b0;
         s1_idx  <= '0;
         star_on <= 1'b0;
         star_r  <= '0;
         star_g  <= '0;
         star_b  <= '0;
      end else begin
         s1_hit  <= any_hit;
         s1_idx  <= first_idx;
         star_on <= s1_hit;
         star_r  <= s1_hit ? prod_r[15:8] : '0;
         star_g  <= s1_hit ? prod_g[15:8] : '0;
         star_b  <= s1_hit ? prod_b[15:8] : '0;
      end
   end

endmodule

// File: tb/tb_starfield_engine.sv
// Directed bench for starfield_engine with a behavioural star-table model.
module tb_starfield_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [31:0] writedata;
   logic        write, chipselect;
   logic [2:0]  address;
   logic        star_on, init_done;
   logic [7:0]  star_r, star_g, star_b;

   always #10 clk = ~clk;

   starfield_engine #(.STAR_COUNT(64), .LAYERS(4), .H_ACTIVE(640), .V_ACTIVE(480), .SEED(16'hBEEF)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .writedata(writedata), .write(write), .chipselect(chipselect), .address(address),
      .star_on(star_on), .star_r(star_r), .star_g(star_g), .star_b(star_b),
      .init_done(init_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [9:0]  mx [64];
   logic [9:0]  my [64];
   logic [15:0] ml;
   logic [7:0]  mtw;
   logic [3:0]  mrate, mlen;
   logic        mtw_en, mdir, men;
   logic [31:0] mspeed;
   logic [23:0] mcol;

   function automatic logic [15:0] step16(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [9:0] red_x(input logic [9:0] v);
      return (int'(v) >= 640) ? 10'(int'(v) - 640) : v;
   endfunction

   function automatic logic [9:0] red_y(input logic [8:0] v);
      return (int'(v) >= 480) ? 10'(int'(v) - 480) : {1'b0, v};
   endfunction

   task automatic model_init(input logic [15:0] seed);
      ml = seed;
      for (int i = 0; i < 64; i++) begin
         mx[i] = red_x(ml[9:0]);
         ml    = step16(ml);
         my[i] = red_y(ml[8:0]);
         ml    = step16(ml);
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 64; i++) begin
         int s, y;
         bit wrapped;
         s = int'((mspeed >> (4 * (i % 4))) & 32'hF);
         y = int'(my[i]);
         wrapped = 1'b0;
         if (!mdir) begin
            y = y + s;
            if (y >= 480) begin y = y - 480; wrapped = 1'b1; end
         end else if (y < s) begin
            y = y + 480 - s; wrapped = 1'b1;
         end else begin
            y = y - s;
         end
         my[i] = 10'(y);
         if (wrapped) begin
            mx[i] = red_x(ml[9:0]);
            ml    = step16(ml);
         end
      end
   endtask

   task automatic exp_pixel(input int x, input int y, output logic on, output logic [23:0] rgb);
      int hit;
      logic [7:0] p, lvl;
      hit = -1;
      for (int i = 0; i < 64; i++)
         if (hit < 0 && int'(mx[i]) == x && int'(my[i]) == y && ((mlen >> (i % 4)) & 4'h1) != 4'h0 && men)
            hit = i;
      on  = (hit >= 0);
      rgb = '0;
      if (on) begin
         p = mtw + 8'((hit * 37) % 256);
         if (!mtw_en)  lvl = 8'd255;
         else if (p >= 8'd128) lvl = 8'(2 * (255 - int'(p)));
         else          lvl = 8'(2 * int'(p));
         rgb = {8'((int'(mcol[23:16]) * int'(lvl)) / 256),
                8'((int'(mcol[15:8])  * int'(lvl)) / 256),
                8'((int'(mcol[7:0])   * int'(lvl)) / 256)};
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic probe(input int x, input int y);
      @(negedge clk);
      hcount = 11'(2 * x); vcount = 10'(y);
      @(posedge clk); @(posedge clk); #1;
   endtask

   task automatic check_px(input string tag, input int x, input int y);
      logic on;
      logic [23:0] rgb;
      probe(x, y);
      exp_pixel(x, y, on, rgb);
      chk({tag, "_on"},  32'(star_on), 32'(on));
      chk({tag, "_rgb"}, {8'h0, star_r, star_g, star_b}, {8'h0, rgb});
   endtask

   task automatic pulse_fs();
      @(negedge clk);
      hcount = 11'd0; vcount = 10'd480;
      @(posedge clk); #1;
      hcount = 11'd1; vcount = 10'd0;
   endtask

   task automatic frame();
      pulse_fs();
      mtw = mtw + {4'h0, mrate};
      model_update();
      repeat (70) @(posedge clk);
   endtask

   task automatic wait_init(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!init_done && cyc < 200);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; hcount = 11'd1; vcount = 10'd0;
      writedata = '0; write = 1'b0; chipselect = 1'b0; address = '0;
      men = 1'b1; mdir = 1'b0; mspeed = 32'h0000_4321; mcol = 24'hFFF0A0;
      mrate = 4'd1; mtw_en = 1'b1; mlen = 4'hF; mtw = 8'd0;

      repeat (2) @(posedge clk); #1;
      chk("rst_star_on", 32'(star_on), 32'd0);
      chk("rst_rgb", {8'h0, star_r, star_g, star_b}, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);

      @(negedge clk); reset = 1'b0;
      wait_init(cyc);
      chk("init_cycles", 32'(cyc), 32'd64);
      model_init(16'hBEEF);

      // tw_acc=0, twinkle on: idx0 -> level 0, idx1 -> level 74
      probe(111, 375);
      chk("star0_tw_on", 32'(star_on), 32'd1);
      chk("star0_tw_rgb", {8'h0, star_r, star_g, star_b}, 32'h0);
      probe(int'(mx[1]), int'(my[1]));
      chk("star1_tw_on", 32'(star_on), 32'd1);
      chk("star1_tw_rgb", {8'h0, star_r, star_g, star_b}, 32'h0049452E);

      wr(3'd3, 32'h0000_0001);
      mtw_en = 1'b0;
      probe(111, 375);
      chk("star0_on", 32'(star_on), 32'd1);
      chk("star0_rgb", {8'h0, star_r, star_g, star_b}, 32'h00FEEF9F);
      check_px("row374", 111, 374);

      // one frame, plus a frame-start on the last UPDATE clock that must be ignored
      pulse_fs();
      mtw = mtw + {4'h0, mrate};
      model_update();
      repeat (63) @(posedge clk);
      #1; hcount = 11'd0; vcount = 10'd480;
      @(posedge clk); #1;
      hcount = 11'd1; vcount = 10'd0;
      repeat (6) @(posedge clk);
      probe(111, 376);
      chk("star0_down1_on", 32'(star_on), 32'd1);
      check_px("star0_old", 111, 375);
      check_px("star2_f1", int'(mx[2]), int'(my[2]));

      wr(3'd1, 32'h0000_432F);
      mspeed = 32'h0000_432F;
      for (int f = 0; f < 32; f++) frame();
      check_px("star0_dn32", int'(mx[0]), int'(my[0]));
      check_px("star0_oldx", 111, int'(my[0]));
      check_px("star1_dn32", int'(mx[1]), int'(my[1]));
      check_px("star3_dn32", int'(mx[3]), int'(my[3]));

      wr(3'd0, 32'h0000_0003);
      mdir = 1'b1;
      for (int f = 0; f < 32; f++) frame();
      check_px("star0_up32", int'(mx[0]), int'(my[0]));
      check_px("star2_up32", int'(mx[2]), int'(my[2]));

      wr(3'd4, 32'h0000_000E);
      mlen = 4'hE;
      check_px("star0_lay_off", int'(mx[0]), int'(my[0]));
      check_px("star1_lay_on", int'(mx[1]), int'(my[1]));
      wr(3'd4, 32'h0000_000F);
      mlen = 4'hF;

      wr(3'd3, 32'h0000_0101);
      mtw_en = 1'b1;
      check_px("star0_twk", int'(mx[0]), int'(my[0]));
      check_px("star5_twk", int'(mx[5]), int'(my[5]));
      wr(3'd7, 32'h0000_0000);
      check_px("undef_addr", int'(mx[0]), int'(my[0]));

      // reseed with 0 in the middle of an UPDATE
      pulse_fs();
      mtw = mtw + {4'h0, mrate};
      repeat (10) @(posedge clk);
      wr(3'd5, 32'h0000_0000);
      chk("reseed_drop", 32'(init_done), 32'd0);
      pulse_fs();
      wait_init(cyc);
      chk("reinit_cycles", 32'(cyc + 1), 32'd64);
      model_init(16'hBEEF);
      check_px("reinit_star0_tw", 111, 375);
      check_px("reinit_star7", int'(mx[7]), int'(my[7]));
      wr(3'd3, 32'h0000_0001);
      mtw_en = 1'b0;
      probe(111, 375);
      chk("reinit_star0_rgb", {8'h0, star_r, star_g, star_b}, 32'h00FEEF9F);

      wr(3'd5, 32'h0000_1234);
      wait_init(cyc);
      chk("seed1234_cycles", 32'(cyc), 32'd64);
      model_init(16'h1234);
      check_px("seed1234_star0", int'(mx[0]), int'(my[0]));
      check_px("seed1234_star1", int'(mx[1]), int'(my[1]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
